key_debounce_encoder: RTL and testbench

Calculator keypad stage directly downstream of the column ring counter and the raw button detector. Each enabled clock it samples the one-hot column drive and the four row lines, and gathers one full four-column scan. It then debounces the result over several consecutive scans and emits a 4-bit key code with a single-cycle valid strobe. Its output feeds the calculator's operand/operator entry logic.

---
 rtl/key_debounce_encoder.sv | 166 ++++++++++++++++
 tb/tb_key_debounce_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_encoder.sv
// Keypad scan accumulator, debouncer and key encoder for the calculator front end.
// Optional auto-repeat of the held key when KEY_REPEAT_EN is defined.
module key_debounce_encoder #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] cols,
  input  logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("key_debounce_encoder: parameter out of range");
  end

  state_t     state;
  logic [1:0] hit_cnt;
  logic [3:0] scan_code;
  logic [3:0] cand;
  logic [3:0] db_cnt;

  logic       col_valid;
  logic [1:0] col_idx;
  logic [1:0] row_idx;
  logic [2:0] row_hits;
  logic [2:0] hit_sum;
  logic [1:0] hit_next;
  logic [3:0] code_next;
  logic       sample;
  logic       end_scan;
  logic       scan_none;
  logic       scan_key;

  // Fold this cycle's sample into the running scan so end of scan sees the full result.
  always_comb begin
    col_valid = 1'b1;
    col_idx   = 2'd0;
    case (cols)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_valid = 1'b0;
    endcase

    if (rows[0])      row_idx = 2'd0;
    else if (rows[1]) row_idx = 2'd1;
    else if (rows[2]) row_idx = 2'd2;
    else              row_idx = 2'd3;

    row_hits  = {2'b00, rows[0]} + {2'b00, rows[1]} + {2'b00, rows[2]} + {2'b00, rows[3]};
    hit_sum   = {1'b0, hit_cnt} + row_hits;
    hit_next  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_next = (|rows) ? {row_idx, col_idx} : scan_code;

    sample    = enable & col_valid;
    end_scan  = sample & cols[3];
    scan_none = (hit_next == 2'd0);
    scan_key  = (hit_next == 2'd1);
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RPT_TARGET = RW'(REPEAT_SCANS);
  logic [RW-1:0] rpt_cnt;
`endif

  // Multi-hit scans fall through to the "not a clean key" branches, so ghosting never strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hit_cnt   <= 2'd0;
      scan_code <= 4'd0;
      cand      <= 4'd0;
      db_cnt    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (sample && !end_scan) begin
        hit_cnt   <= hit_next;
        scan_code <= code_next;
      end else if (end_scan) begin
        hit_cnt   <= 2'd0;
        scan_code <= 4'd0;
        case (state)
          IDLE: begin
            if (scan_key) begin
              state  <= DB_PRESS;
              cand   <= code_next;
              db_cnt <= 4'd1;
            end
          end
          DB_PRESS: begin
            if (scan_key && code_next == cand) begin
              if (db_cnt + 4'd1 == DB_TARGET) begin
                state     <= PRESSED;
                db_cnt    <= 4'd0;
                key_valid <= 1'b1;
                key_code  <= cand;
                key_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
                rpt_cnt   <= '0;
`endif
              end else begin
                db_cnt <= db_cnt + 4'd1;
              end
            end else if (scan_key) begin
              cand   <= code_next;
              db_cnt <= 4'd1;
            end else begin
              state  <= IDLE;
              db_cnt <= 4'd0;
            end
          end
          PRESSED: begin
            if (scan_none) begin
              state  <= DB_RELEASE;
              db_cnt <= 4'd1;
`ifdef KEY_REPEAT_EN
              rpt_cnt <= '0;
            end else if (rpt_cnt + RW'(1) == RPT_TARGET) begin
              rpt_cnt <= '0;
              if (!key_valid) key_valid <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
`endif
            end
          end
          DB_RELEASE: begin
`ifdef KEY_REPEAT_EN
            rpt_cnt <= '0;
`endif
            if (scan_none) begin
              if (db_cnt + 4'd1 == DB_TARGET) begin
                state    <= IDLE;
                db_cnt   <= 4'd0;
                key_held <= 1'b0;
              end else begin
                db_cnt <= db_cnt + 4'd1;
              end
            end else begin
              state  <= PRESSED;
              db_cnt <= 4'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder with DEBOUNCE_SCANS=4, REPEAT_SCANS=16.
// Repeat expectations follow KEY_REPEAT_EN when it is defined for the build.
module tb_key_debounce_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int strobe_count = 0;
  int strobe_cycle = -1;
  int fall_cycle = -1;
  int eos_cycle = -1;
  int base;
  int exp_hold;
  logic [3:0] last_code = 4'd0;
  logic prev_valid = 1'b0;
  logic prev_held = 1'b0;

  key_debounce_encoder #(.DEBOUNCE_SCANS(4), .REPEAT_SCANS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cols(cols), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Strobe bookkeeping; also guards against back-to-back strobes.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      checkOutput("no_back_to_back", {31'd0, prev_valid}, 32'd0);
      strobe_count++;
      last_code = key_code;
      strobe_cycle = cycle;
    end
    if (prev_held === 1'b1 && key_held === 1'b0) fall_cycle = cycle;
    prev_valid = key_valid;
    prev_held = key_held;
  end

  function automatic logic [3:0] rows_for(input logic [15:0] keys, input int c);
    return {keys[12+c], keys[8+c], keys[4+c], keys[c]};
  endfunction

  // keys bit index is {row_idx, col_idx}; glitch adds an ignored disabled/multi-hot cycle mid-scan.
  task automatic applyStimulus(input logic [15:0] keys, input int nscans, input bit glitch);
    for (int s = 0; s < nscans; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        enable = 1'b1;
        cols = 4'(1 << c);
        rows = rows_for(keys, c);
        if (c == 3) eos_cycle = cycle;
        if (glitch && c == 1) begin
          @(negedge clk);
          enable = 1'b0;
          cols = 4'b1000;
          rows = 4'hF;
          @(negedge clk);
          enable = 1'b1;
          cols = 4'b0110;
          rows = 4'hF;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b1;
      cols = 4'b0000;
      rows = 4'h0;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    cols = 4'b0000;
    rows = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    cols = 4'b0000;
    rows = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_code", {28'd0, key_code}, 32'd0);
    checkOutput("reset_valid", {31'd0, key_valid}, 32'd0);
    checkOutput("reset_held", {31'd0, key_held}, 32'd0);
    reset = 1'b0;

    $display("[TB] idle scans after reset");
    applyStimulus(16'h0000, 10, 1'b0);
    idleCycles(2);
    checkOutput("idle_no_strobe", strobe_count, 32'd0);

    $display("[TB] R2.C3 press");
    base = strobe_count;
    applyStimulus(16'h0040, 4, 1'b0);
    idleCycles(2);
    checkOutput("r2c3_count", strobe_count - base, 32'd1);
    checkOutput("r2c3_code", {28'd0, last_code}, 32'd6);
    checkOutput("r2c3_timing", strobe_cycle, eos_cycle + 1);
    checkOutput("r2c3_held", {31'd0, key_held}, 32'd1);
    applyStimulus(16'h0000, 4, 1'b0);
    idleCycles(2);
    checkOutput("r2c3_release_held", {31'd0, key_held}, 32'd0);
    checkOutput("r2c3_fall_timing", fall_cycle, eos_cycle + 1);
    checkOutput("code_holds", {28'd0, key_code}, 32'd6);

    $display("[TB] bouncing R1.C2");
    base = strobe_count;
    applyStimulus(16'h0002, 2, 1'b0);
    applyStimulus(16'h0000, 1, 1'b0);
    applyStimulus(16'h0002, 3, 1'b0);
    idleCycles(2);
    checkOutput("bounce_early", strobe_count - base, 32'd0);
    applyStimulus(16'h0002, 1, 1'b0);
    idleCycles(2);
    checkOutput("bounce_count", strobe_count - base, 32'd1);
    checkOutput("bounce_code", {28'd0, last_code}, 32'd1);
    checkOutput("bounce_timing", strobe_cycle, eos_cycle + 1);
    applyStimulus(16'h0000, 4, 1'b0);

    $display("[TB] ghost pair then R4.C4");
    base = strobe_count;
    applyStimulus(16'h0201, 8, 1'b0);
    idleCycles(2);
    checkOutput("ghost_no_strobe", strobe_count - base, 32'd0);
    checkOutput("ghost_not_held", {31'd0, key_held}, 32'd0);
    applyStimulus(16'h0000, 2, 1'b0);
    applyStimulus(16'h8000, 4, 1'b0);
    idleCycles(2);
    checkOutput("r4c4_count", strobe_count - base, 32'd1);
    checkOutput("r4c4_code", {28'd0, key_code}, 32'd15);
    applyStimulus(16'h0000, 4, 1'b0);

    $display("[TB] release bounce on R3.C1");
    base = strobe_count;
    applyStimulus(16'h0100, 4, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    applyStimulus(16'h0100, 1, 1'b0);
    applyStimulus(16'h0000, 3, 1'b0);
    idleCycles(2);
    checkOutput("rel_bounce_held", {31'd0, key_held}, 32'd1);
    applyStimulus(16'h0000, 1, 1'b0);
    idleCycles(2);
    checkOutput("rel_bounce_fall", {31'd0, key_held}, 32'd0);
    checkOutput("rel_bounce_fall_timing", fall_cycle, eos_cycle + 1);
    checkOutput("rel_bounce_count", strobe_count - base, 32'd1);
    checkOutput("rel_bounce_code", {28'd0, last_code}, 32'd8);

    $display("[TB] enable gaps and multi-hot columns on R2.C4");
    base = strobe_count;
    applyStimulus(16'h0080, 4, 1'b1);
    idleCycles(2);
    checkOutput("gap_count", strobe_count - base, 32'd1);
    checkOutput("gap_code", {28'd0, last_code}, 32'd7);
    checkOutput("gap_timing", strobe_cycle, eos_cycle + 1);
    applyStimulus(16'h0000, 4, 1'b0);

    $display("[TB] reset mid-debounce on R2.C2");
    base = strobe_count;
    applyStimulus(16'h0020, 3, 1'b0);
    pulseReset();
    checkOutput("mid_reset_held", {31'd0, key_held}, 32'd0);
    checkOutput("mid_reset_code", {28'd0, key_code}, 32'd0);
    applyStimulus(16'h0020, 3, 1'b0);
    idleCycles(2);
    checkOutput("mid_reset_fresh", strobe_count - base, 32'd0);
    applyStimulus(16'h0020, 1, 1'b0);
    idleCycles(2);
    checkOutput("mid_reset_count", strobe_count - base, 32'd1);
    checkOutput("mid_reset_code2", {28'd0, last_code}, 32'd5);
    applyStimulus(16'h0000, 4, 1'b0);

    $display("[TB] long hold on R3.C3");
`ifdef KEY_REPEAT_EN
    exp_hold = 3;
`else
    exp_hold = 1;
`endif
    base = strobe_count;
    applyStimulus(16'h0400, 40, 1'b1);
    idleCycles(2);
    checkOutput("hold_count", strobe_count - base, exp_hold);
    checkOutput("hold_code", {28'd0, last_code}, 32'd10);
    applyStimulus(16'h0000, 4, 1'b0);
    idleCycles(2);
    checkOutput("hold_release", {31'd0, key_held}, 32'd0);
    checkOutput("hold_no_extra", strobe_count - base, exp_hold);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
